jk_mod_counter: RTL and testbench
=================================

JK_MOD_COUNTER -- requirements
Module: jk_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter bit width (legal range 2..8).
REQ-002 clk  input  1  rising-edge clock; the block's only clock.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 en  input  1  count enable.
REQ-005 up  input  1  direction: 1 = up, 0 = down.
REQ-006 load  input  1  synchronous parallel load strobe.
REQ-007 load_val  input  WIDTH  value written on load.
REQ-008 max_cnt  input  WIDTH  terminal value; count sequence is 0..max_cnt (modulus max_cnt+1).
REQ-009 q  output  WIDTH  registered count.
REQ-010 qb  output  WIDTH  registered complement of q.
REQ-011 j_o  output  WIDTH  combinational per-bit J excitation driving the next edge.
REQ-012 k_o  output  WIDTH  combinational per-bit K excitation driving the next edge.
REQ-013 tc  output  1  combinational terminal-count flag.
REQ-014 wrap  output  1  registered one-cycle wrap pulse.

Function
REQ-015 State register SHALL update every bit on rising clk strictly by the JK rule on (j_o[i], k_o[i]): 00 hold, 01 clear, 10 set, 11 toggle.
REQ-016 qb SHALL equal ~q at all times, including immediately after reset.
REQ-017 Priority SHALL be rst > load > en; when none is active, j_o = k_o = 0 and q holds.
REQ-018 On load: j_o = load_val, k_o = ~load_val, regardless of en, up or max_cnt; the next q equals load_val.
REQ-019 On count (en=1, load=0): j_o[i] = k_o[i] = q[i] XOR nxt[i], where nxt is the next count defined below.
REQ-020 Up count: nxt = 0 if q >= max_cnt, else q+1.
REQ-021 Down count: nxt = max_cnt if q == 0 or q > max_cnt, else q-1.
REQ-022 Arithmetic SHALL be unsigned and modulo 2^WIDTH internally; q never exceeds max_cnt through counting, only through load.
REQ-023 tc = en & ~load & ((up & q >= max_cnt) | (~up & q == 0)).
REQ-024 wrap SHALL be 1 for exactly the cycle after an edge at which tc was 1, otherwise 0.
REQ-025 max_cnt = 0: q SHALL stay 0 when enabled, and tc and wrap SHALL assert on every enabled cycle.
REQ-026 A change of max_cnt or up mid-count SHALL take effect at the next edge, with no extra latency.
REQ-027 A load on the same edge as a terminal condition SHALL suppress wrap; load always wins.

Reset
REQ-028 With rst=1 at a rising edge: q = 0, qb = all ones, wrap = 0 after that edge, regardless of load or en.
REQ-029 While rst=1, j_o/k_o SHALL be forced to 0 and tc to 0.
REQ-030 Reset asserted mid-count SHALL abort the sequence; counting resumes from 0 on the first edge with rst=0.

Verification
REQ-031 rst=1 for 2 edges, then en=1, up=1, max_cnt=9 for 12 edges -> q = 1..9, 0, 1, 2; tc high while q=9; wrap high the cycle q=0 first appears; qb = ~q throughout.
REQ-032 Down count from q=0 with max_cnt=5 -> q = 5, 4, 3, 2, 1, 0, 5; tc high at q=0 (1st and 7th cycles); wrap follows each by one cycle.
REQ-033 load=1, load_val=4'hC, max_cnt=9, en=1, up=1 -> the load edge shows j_o=1100, k_o=0011, q=C; the next up edge gives q=0, wrap=1; repeat with up=0 -> q=9.
REQ-034 q=0111, en=1, up=1, max_cnt=15 -> j_o=k_o=1111 (all-toggle) and q=1000 next; with en=0, j_o=k_o=0000 and q holds for 3 edges.
REQ-035 max_cnt=0, en=1 for 4 edges -> q stays 0; tc=1 and wrap=1 every cycle after the first edge.
REQ-036 rst=1 asserted at q=6 together with load=1 -> q=0, qb=1111, wrap=0; the first enabled up edge after release gives q=1.

Source files
------------

// File: rtl/jk_mod_counter.sv
// jk_mod_counter: modulo up/down counter whose state register is built
// from per-bit JK flip-flops. The J/K excitation for each bit is derived
// combinationally from the desired next count, so the register itself only
// ever applies the JK rule (00 hold, 01 clear, 10 set, 11 toggle).
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   en        count enable
//   up        direction, 1 = up, 0 = down
//   load      synchronous parallel load strobe (beats en)
//   load_val  value written on load
//   max_cnt   terminal value; sequence is 0..max_cnt
//   q, qb     registered count and its registered complement
//   j_o, k_o  combinational J/K excitation applied at the next edge
//   tc        combinational terminal-count flag
//   wrap      registered pulse, high the cycle after an edge where tc was 1
module jk_mod_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_C = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] qb_r;
    logic             wrap_r;
    logic [WIDTH-1:0] nxt_s;
    logic [WIDTH-1:0] j_s;
    logic [WIDTH-1:0] k_s;
    logic             tc_s;

    // JK characteristic equation applied bitwise: Q+ = J&~Q | ~K&Q.
    function automatic logic [WIDTH-1:0] jk_apply(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] j,
        input logic [WIDTH-1:0] k
    );
        jk_apply = (j & ~cur) | (~k & cur);
    endfunction

    // Next count value; out-of-range states (only reachable by load) fold
    // back into the legal range: up goes to 0, down goes to max_cnt.
    always_comb begin
        nxt_s = q_r;
        if (up) begin
            if (q_r >= max_cnt) begin
                nxt_s = ZERO_C;
            end else begin
                nxt_s = q_r + ONE_C;
            end
        end else begin
            if ((q_r == ZERO_C) || (q_r > max_cnt)) begin
                nxt_s = max_cnt;
            end else begin
                nxt_s = q_r - ONE_C;
            end
        end
    end

    // J/K excitation and terminal count with priority rst > load > en.
    always_comb begin
        j_s  = ZERO_C;
        k_s  = ZERO_C;
        tc_s = 1'b0;
        if (rst) begin
            j_s  = ZERO_C;
            k_s  = ZERO_C;
            tc_s = 1'b0;
        end else if (load) begin
            j_s  = load_val;
            k_s  = ~load_val;
            tc_s = 1'b0;
        end else if (en) begin
            // Toggle exactly the bits that differ between q and the next count.
            j_s  = q_r ^ nxt_s;
            k_s  = q_r ^ nxt_s;
            tc_s = up ? (q_r >= max_cnt) : (q_r == ZERO_C);
        end else begin
            j_s  = ZERO_C;
            k_s  = ZERO_C;
            tc_s = 1'b0;
        end
    end

    // State, complement and wrap registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r    <= ZERO_C;
            qb_r   <= ONES_C;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= jk_apply(q_r, j_s, k_s);
            qb_r   <= ~jk_apply(q_r, j_s, k_s);
            wrap_r <= tc_s;
        end
    end

    assign q    = q_r;
    assign qb   = qb_r;
    assign wrap = wrap_r;
    assign j_o  = j_s;
    assign k_o  = k_s;
    assign tc   = tc_s;

endmodule

// File: tb/tb_jk_mod_counter.sv
module tb_jk_mod_counter;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst, en, up, load;
    logic [W-1:0] load_val, max_cnt;
    logic [W-1:0] q, qb, j_o, k_o;
    logic         tc, wrap;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state
    int q_m   = 0;
    int max_m = 0;

    always #5 clk = ~clk;

    jk_mod_counter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .max_cnt(max_cnt),
        .q(q), .qb(qb), .j_o(j_o), .k_o(k_o), .tc(tc), .wrap(wrap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next count from the modulo rules, in plain integer arithmetic.
    function automatic int ref_next(input int cur, input int mx, input bit dir_up);
        if (dir_up) return (cur >= mx) ? 0 : cur + 1;
        else        return (cur == 0 || cur > mx) ? mx : cur - 1;
    endfunction

    // One clock: drive inputs, check combinational outputs, clock, check registers.
    task automatic step(input bit r, input bit e, input bit u, input bit l,
                        input int lv, input int mx);
        int  nq;
        bit  tc_e;
        int  jk_e;
        int  j_e;
        int  k_e;
        rst = r; en = e; up = u; load = l;
        load_val = W'(lv); max_cnt = W'(mx);
        #2;
        if (r) begin
            nq = 0; tc_e = 1'b0; j_e = 0; k_e = 0;
        end else if (l) begin
            nq = lv; tc_e = 1'b0; j_e = lv; k_e = (~lv) & MASK;
        end else if (e) begin
            nq   = ref_next(q_m, mx, u);
            tc_e = u ? (q_m >= mx) : (q_m == 0);
            jk_e = q_m ^ nq;
            j_e  = jk_e; k_e = jk_e;
        end else begin
            nq = q_m; tc_e = 1'b0; j_e = 0; k_e = 0;
        end
        chk("j_o", 32'(j_o), 32'(j_e));
        chk("k_o", 32'(k_o), 32'(k_e));
        chk("tc",  32'(tc),  32'(tc_e));
        @(posedge clk);
        #1;
        q_m = nq;
        chk("q",    32'(q),    32'(q_m));
        chk("qb",   32'(qb),   32'((~q_m) & MASK));
        chk("wrap", 32'(wrap), 32'(tc_e));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0;
        load_val = '0; max_cnt = '0;
        @(posedge clk); #1;

        // Reset for two edges, then up count modulo 10.
        step(1, 0, 1, 0, 0, 9);
        step(1, 1, 1, 1, 5, 9);
        chk("reset_q_const",  32'(q),  32'h0);
        chk("reset_qb_const", 32'(qb), 32'hF);
        for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0, 9);
        chk("up_end_const", 32'(q), 32'h2);

        // Down count from 0 with max 5.
        step(0, 0, 1, 1, 0, 5);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0, 5);
        chk("down_end_const", 32'(q), 32'h5);

        // Load above max_cnt, then fold back up and down.
        rst = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'hC; max_cnt = 4'h9;
        #1;
        chk("load_j_const", 32'(j_o), 32'hC);
        chk("load_k_const", 32'(k_o), 32'h3);
        step(0, 1, 1, 1, 12, 9);
        step(0, 1, 1, 0, 0, 9);
        chk("fold_up_const", 32'(q), 32'h0);
        step(0, 1, 0, 1, 12, 9);
        step(0, 1, 0, 0, 0, 9);
        chk("fold_down_const", 32'(q), 32'h9);

        // All-bit toggle 0111 -> 1000, then hold.
        step(0, 0, 1, 1, 7, 15);
        rst = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; max_cnt = 4'hF;
        #1;
        chk("toggle_j_const", 32'(j_o), 32'hF);
        step(0, 1, 1, 0, 0, 15);
        chk("toggle_q_const", 32'(q), 32'h8);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 15);

        // max_cnt = 0 keeps q at 0 with tc/wrap every enabled cycle.
        step(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 0);
        chk("max0_wrap_const", 32'(wrap), 32'h1);

        // Reset mid-count at q=6 together with load.
        step(0, 0, 1, 1, 0, 9);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0, 9);
        chk("pre_rst_const", 32'(q), 32'h6);
        step(1, 1, 1, 1, 13, 9);
        step(0, 1, 1, 0, 0, 9);
        chk("post_rst_const", 32'(q), 32'h1);

        // Randomized traffic, including mid-count max/direction changes.
        max_m = 9;
        for (int i = 0; i < 400; i++) begin
            bit r, e, u, l;
            if ($urandom_range(9) == 0) max_m = int'($urandom_range(MASK));
            r = ($urandom_range(29) == 0);
            l = ($urandom_range(7) == 0);
            e = ($urandom_range(3) != 0);
            u = 1'($urandom_range(1));
            step(r, e, u, l, int'($urandom_range(MASK)), max_m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
